// File: rtl/cpu_fetch_sequencer.sv
// System-cycle sequencer and instruction fetcher for the 4-bit CPU core.
// Optional stop/stop_ack handshake is enabled by defining CPU_FETCH_STOP_EN.
module cpu_fetch_sequencer #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned CYCLES     = 8,
  parameter int unsigned EXEC_CYCLE = 5,
  localparam int unsigned CW        = $clog2(CYCLES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data,
`ifdef CPU_FETCH_STOP_EN
  input  logic                  stop,
  output logic                  stop_ack,
`endif
  output logic [CW-1:0]         cycle,
  output logic                  sync,
  output logic [2*DATA_W-1:0]   inst,
  output logic [2*DATA_W-1:0]   inst2,
  output logic                  second_word,
  output logic                  pc_hold,
  output logic                  rom_addr_sel,
  output logic                  exec_strobe,
  output logic                  inst_done
);

  localparam logic [CW-1:0] LAST_CYC = CW'(CYCLES - 1);
  localparam logic [CW-1:0] HI_CYC   = CW'(3);
  localparam logic [CW-1:0] LO_CYC   = CW'(4);
  localparam logic [CW-1:0] EXE_CYC  = CW'(EXEC_CYCLE);

  typedef enum logic [1:0] {
    S_FETCH1   = 2'd0,
    S_FETCH2   = 2'd1,
    S_INDIRECT = 2'd2
`ifdef CPU_FETCH_STOP_EN
    ,S_STOPPED = 2'd3
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cycle;
  logic [2*DATA_W-1:0]   r_inst;
  logic [2*DATA_W-1:0]   r_inst2;
  logic                  r_second_word;
  logic                  r_pc_hold;
  logic                  r_rom_addr_sel;
  logic                  w_last;
  logic                  w_two_word;
  logic                  w_fin;
  logic                  w_final;
  logic                  w_halt_req;
  logic [3:0]            w_opcode;

  assign w_last   = (r_cycle == LAST_CYC);
  assign w_opcode = r_inst[2*DATA_W-1 -: 4];

`ifdef CPU_FETCH_STOP_EN
  logic r_stop_ack;
  assign w_halt_req = stop;
  assign stop_ack   = r_stop_ack;
`else
  assign w_halt_req = 1'b0;
`endif

  always_comb begin
    w_two_word = 1'b0;
    w_fin      = 1'b0;
    case (w_opcode)
      4'h1, 4'h4, 4'h5, 4'h7: w_two_word = 1'b1;
      4'h2:                   w_two_word = ~r_inst[0];
      4'h3:                   w_fin      = ~r_inst[0];
      default: ;
    endcase
  end

  // Counter and word capture; capture is steered by the current state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle <= '0;
      r_inst  <= '0;
      r_inst2 <= '0;
    end else begin
      r_cycle <= w_last ? '0 : r_cycle + CW'(1);
      if (r_state == S_FETCH1) begin
        if (r_cycle == HI_CYC) r_inst[2*DATA_W-1:DATA_W] <= data;
        if (r_cycle == LO_CYC) r_inst[DATA_W-1:0]        <= data;
      end else if (r_state == S_FETCH2 || r_state == S_INDIRECT) begin
        if (r_cycle == HI_CYC) r_inst2[2*DATA_W-1:DATA_W] <= data;
        if (r_cycle == LO_CYC) r_inst2[DATA_W-1:0]        <= data;
      end
    end
  end

  // State register; the per-state outputs are registered from the next state
  // so they are glitch-free and stable for the whole system cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_FETCH1;
      r_second_word  <= 1'b0;
      r_pc_hold      <= 1'b0;
      r_rom_addr_sel <= 1'b0;
`ifdef CPU_FETCH_STOP_EN
      r_stop_ack     <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_second_word  <= (w_state_nxt == S_FETCH2) || (w_state_nxt == S_INDIRECT);
      r_rom_addr_sel <= (w_state_nxt == S_INDIRECT);
`ifdef CPU_FETCH_STOP_EN
      r_pc_hold      <= (w_state_nxt == S_INDIRECT) || (w_state_nxt == S_STOPPED);
      r_stop_ack     <= (w_state_nxt == S_STOPPED);
`else
      r_pc_hold      <= (w_state_nxt == S_INDIRECT);
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_last) begin
      case (r_state)
        S_FETCH1: begin
          if (w_two_word)  w_state_nxt = S_FETCH2;
          else if (w_fin)  w_state_nxt = S_INDIRECT;
`ifdef CPU_FETCH_STOP_EN
          else if (w_halt_req) w_state_nxt = S_STOPPED;
`endif
          else             w_state_nxt = S_FETCH1;
        end
        S_FETCH2, S_INDIRECT: begin
`ifdef CPU_FETCH_STOP_EN
          w_state_nxt = w_halt_req ? S_STOPPED : S_FETCH1;
`else
          w_state_nxt = S_FETCH1;
`endif
        end
`ifdef CPU_FETCH_STOP_EN
        S_STOPPED: w_state_nxt = w_halt_req ? S_STOPPED : S_FETCH1;
`endif
        default: w_state_nxt = S_FETCH1;
      endcase
    end
  end

  // Final system cycle: a 1-word FETCH1, or the second cycle of a 2-cycle instruction.
  always_comb begin
    w_final = 1'b0;
    case (r_state)
      S_FETCH1:             w_final = ~w_two_word & ~w_fin;
      S_FETCH2, S_INDIRECT: w_final = 1'b1;
      default:              w_final = 1'b0;
    endcase
    exec_strobe = w_final && (r_cycle == EXE_CYC);
    inst_done   = w_final && w_last;
    sync        = ~w_last;
  end

  assign cycle        = r_cycle;
  assign inst         = r_inst;
  assign inst2        = r_inst2;
  assign second_word  = r_second_word;
  assign pc_hold      = r_pc_hold;
  assign rom_addr_sel = r_rom_addr_sel;

  logic w_unused;
  assign w_unused = w_halt_req;

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Directed self-checking bench for cpu_fetch_sequencer (DATA_W=4, CYCLES=8, EXEC_CYCLE=5).
module tb_cpu_fetch_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data  = '0;
  logic [2:0] cycle;
  logic       sync, second_word, pc_hold, rom_addr_sel, exec_strobe, inst_done;
  logic [7:0] inst, inst2;
`ifdef CPU_FETCH_STOP_EN
  logic       stop = 1'b0;
  logic       stop_ack;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  cpu_fetch_sequencer #(.DATA_W(4), .CYCLES(8), .EXEC_CYCLE(5)) dut (
    .clock(clock), .reset(reset), .data(data),
`ifdef CPU_FETCH_STOP_EN
    .stop(stop), .stop_ack(stop_ack),
`endif
    .cycle(cycle), .sync(sync), .inst(inst), .inst2(inst2),
    .second_word(second_word), .pc_hold(pc_hold), .rom_addr_sel(rom_addr_sel),
    .exec_strobe(exec_strobe), .inst_done(inst_done)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic wait_cycle(input int k);
    int n = 0;
    while (cycle !== 3'(k) && n < 16) begin step(); n++; end
    n_cmp++;
    if (cycle !== 3'(k)) begin n_bad++; $display("FAIL wait_cycle: cycle=%0d required=%0d", cycle, k); end
  endtask

  task automatic do_reset();
    reset = 1'b1; data = '0;
    step(); step();
    reset = 1'b0;
  endtask

  // Presents one word in the current system cycle; returns observing cycle 5.
  task automatic present(input logic [3:0] hi, input logic [3:0] lo);
    wait_cycle(3);
    data = hi; step();
    data = lo; step();
    data = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (cycle !== 3'd0) begin n_bad++; $display("FAIL reset_cycle: got %0d want 0", cycle); end
    n_cmp++; if (inst !== 8'h00 || inst2 !== 8'h00) begin n_bad++; $display("FAIL reset_words: got %h/%h want 00/00", inst, inst2); end
    n_cmp++; if (sync !== 1'b1) begin n_bad++; $display("FAIL reset_sync: got %b want 1", sync); end
    n_cmp++; if ({second_word, pc_hold, rom_addr_sel, exec_strobe, inst_done} !== 5'b0)
      begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {second_word, pc_hold, rom_addr_sel, exec_strobe, inst_done}); end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (cycle !== 3'(i % 8)) begin n_bad++; $display("FAIL free_cycle[%0d]: got %0d want %0d", i, cycle, i % 8); end
      n_cmp++; if (sync !== 1'((i % 8) != 7)) begin n_bad++; $display("FAIL free_sync[%0d]: got %b want %b", i, sync, (i % 8) != 7); end
      if (i < 8) begin
        n_cmp++;
        if (exec_strobe !== 1'(i == 5) || inst_done !== 1'(i == 7))
          begin n_bad++; $display("FAIL free_strobes[%0d]: got %b%b want %b%b", i, exec_strobe, inst_done, i == 5, i == 7); end
      end
      step();
    end
  endtask

  task automatic test_one_word();
    do_reset();
    present(4'hD, 4'h5);
    n_cmp++; if (inst !== 8'hD5) begin n_bad++; $display("FAIL one_inst: got %h want d5", inst); end
    n_cmp++; if (second_word !== 1'b0) begin n_bad++; $display("FAIL one_second_word: got %b want 0", second_word); end
    n_cmp++; if (exec_strobe !== 1'b1) begin n_bad++; $display("FAIL one_exec: got %b want 1", exec_strobe); end
    step();
    n_cmp++; if (exec_strobe !== 1'b0) begin n_bad++; $display("FAIL one_exec_pulse: got %b want 0", exec_strobe); end
    step();
    n_cmp++; if (inst_done !== 1'b1) begin n_bad++; $display("FAIL one_done: got %b want 1", inst_done); end
  endtask

  task automatic test_fim();
    do_reset();
    present(4'h2, 4'h4);
    n_cmp++; if (inst !== 8'h24 || exec_strobe !== 1'b0) begin n_bad++; $display("FAIL fim_first: got %h/%b want 24/0", inst, exec_strobe); end
    step(); step();
    n_cmp++; if (inst_done !== 1'b0) begin n_bad++; $display("FAIL fim_first_done: got %b want 0", inst_done); end
    step();
    for (int c = 0; c < 8; c++) begin
      if (c == 3) data = 4'hA;
      if (c == 4) data = 4'hB;
      n_cmp++; if (second_word !== 1'b1) begin n_bad++; $display("FAIL fim_second_word[%0d]: got %b want 1", c, second_word); end
      n_cmp++; if (exec_strobe !== 1'(c == 5) || inst_done !== 1'(c == 7))
        begin n_bad++; $display("FAIL fim_strobes[%0d]: got %b%b want %b%b", c, exec_strobe, inst_done, c == 5, c == 7); end
      if (c == 5) begin
        n_cmp++; if (inst2 !== 8'hAB || inst !== 8'h24) begin n_bad++; $display("FAIL fim_words: got %h/%h want 24/ab", inst, inst2); end
      end
      step();
    end
    data = '0;
    n_cmp++; if (second_word !== 1'b0) begin n_bad++; $display("FAIL fim_return: got %b want 0", second_word); end
  endtask

  task automatic test_fin();
    do_reset();
    present(4'h3, 4'h2);
    n_cmp++; if (pc_hold !== 1'b0 || exec_strobe !== 1'b0) begin n_bad++; $display("FAIL fin_first: got %b/%b want 0/0", pc_hold, exec_strobe); end
    step(); step(); step();
    for (int c = 0; c < 8; c++) begin
      if (c == 3) data = 4'h7;
      if (c == 4) data = 4'hE;
      n_cmp++; if ({pc_hold, rom_addr_sel, second_word} !== 3'b111)
        begin n_bad++; $display("FAIL fin_flags[%0d]: got %b want 111", c, {pc_hold, rom_addr_sel, second_word}); end
      if (c == 5) begin
        n_cmp++; if (inst2 !== 8'h7E || exec_strobe !== 1'b1) begin n_bad++; $display("FAIL fin_data: got %h/%b want 7e/1", inst2, exec_strobe); end
      end
      step();
    end
    data = '0;
    n_cmp++; if ({pc_hold, rom_addr_sel} !== 2'b00) begin n_bad++; $display("FAIL fin_return: got %b want 00", {pc_hold, rom_addr_sel}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    present(4'h2, 4'h4);
    step(); step(); step();
    step(); step(); step();
    data = 4'hA; step();
    reset = 1'b1; step();
    n_cmp++; if (cycle !== 3'd0 || inst !== 8'h00 || inst2 !== 8'h00)
      begin n_bad++; $display("FAIL mid_reset_state: got c=%0d %h/%h want 0 00/00", cycle, inst, inst2); end
    reset = 1'b0; data = '0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if ({exec_strobe, inst_done, second_word} !== 3'b000)
        begin n_bad++; $display("FAIL mid_reset_quiet[%0d]: got %b want 000", c, {exec_strobe, inst_done, second_word}); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    present(4'h2, 4'h4); step(); step(); step();
    present(4'hA, 4'hB);
    n_cmp++; if (exec_strobe !== 1'b1 || inst2 !== 8'hAB) begin n_bad++; $display("FAIL b2b_first: got %b/%h want 1/ab", exec_strobe, inst2); end
    step(); step(); step();
    n_cmp++; if (second_word !== 1'b0) begin n_bad++; $display("FAIL b2b_fetch1: got %b want 0", second_word); end
    present(4'h5, 4'h0);
    n_cmp++; if (inst !== 8'h50 || inst2 !== 8'hAB || exec_strobe !== 1'b0)
      begin n_bad++; $display("FAIL b2b_mid: got %h/%h/%b want 50/ab/0", inst, inst2, exec_strobe); end
    step(); step(); step();
    n_cmp++; if (second_word !== 1'b1) begin n_bad++; $display("FAIL b2b_fetch2: got %b want 1", second_word); end
    present(4'hC, 4'hD);
    n_cmp++; if (inst !== 8'h50 || inst2 !== 8'hCD || exec_strobe !== 1'b1)
      begin n_bad++; $display("FAIL b2b_second: got %h/%h/%b want 50/cd/1", inst, inst2, exec_strobe); end
  endtask

`ifdef CPU_FETCH_STOP_EN
  task automatic test_stop();
    do_reset();
    present(4'hD, 4'h5); step(); step();
    stop = 1'b1;
    n_cmp++; if (inst_done !== 1'b1) begin n_bad++; $display("FAIL stop_done: got %b want 1", inst_done); end
    step();
    stop = 1'b0;
    n_cmp++; if (stop_ack !== 1'b1 || pc_hold !== 1'b1) begin n_bad++; $display("FAIL stop_enter: got %b/%b want 1/1", stop_ack, pc_hold); end
    for (int c = 0; c < 8; c++) begin
      if (c == 3 || c == 4) data = 4'hF;
      n_cmp++; if ({exec_strobe, inst_done} !== 2'b00 || stop_ack !== 1'b1)
        begin n_bad++; $display("FAIL stop_idle[%0d]: got %b%b/%b want 00/1", c, exec_strobe, inst_done, stop_ack); end
      if (c == 5) begin
        n_cmp++; if (inst !== 8'hD5) begin n_bad++; $display("FAIL stop_hold: got %h want d5", inst); end
      end
      step();
    end
    data = '0;
    n_cmp++; if (stop_ack !== 1'b0 || pc_hold !== 1'b0) begin n_bad++; $display("FAIL stop_exit: got %b/%b want 0/0", stop_ack, pc_hold); end
    present(4'hC, 4'h0);
    n_cmp++; if (inst !== 8'hC0 || exec_strobe !== 1'b1) begin n_bad++; $display("FAIL stop_resume: got %h/%b want c0/1", inst, exec_strobe); end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_one_word();
    test_fim();
    test_fin();
    test_reset_mid();
    test_back_to_back();
`ifdef CPU_FETCH_STOP_EN
    test_stop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
